// File: rtl/expr_arb_pkg.sv
// Shared types and default widths for the expression-unit arbiter.
package expr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int DATA_W = 4;
    localparam int RES_W  = 20;
    localparam int STAT_W = 16;
    localparam int BUSY_W = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search from ptr upward, wrapping at NUM_REQ.
// The pointer register lives in the parent so the parent decides when a
// grant has actually been taken.
module rr_arbiter
#(
    parameter int NUM_REQ = 4
)
(
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    input  logic                       en,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] idx
);
    import expr_arb_pkg::*;

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] w_sel;
    logic             w_found;

    // First requester at or after ptr wins; nothing is granted when disabled.
    always_comb begin
        grant   = '0;
        idx     = '0;
        w_sel   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sel = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (en && !w_found && req[w_sel]) begin
                w_found      = 1'b1;
                grant[w_sel] = 1'b1;
                idx          = w_sel;
            end
        end
    end

endmodule

// File: rtl/expr_unit_arbiter.sv
// Shares one combinational expression unit among NUM_REQ requesters.
// One operand at a time is held on dp_in for SETTLE cycles, the result is
// captured and returned on a tagged response channel.
// Optional statistics counters are built when EXPR_ARB_STATS_EN is defined.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | arbiter enabled, waiting for any req_valid
// HOLD  | operand held on dp_in, counting settle cycles, capture at end
// RESP  | rsp_valid high until rsp_ready
module expr_unit_arbiter
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = expr_arb_pkg::DATA_W,
    parameter int RES_W   = expr_arb_pkg::RES_W,
    parameter int SETTLE  = 2
)
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]     req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_W-1:0]             dp_in,
    input  logic [RES_W-1:0]              dp_out,
    output logic                          rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
    output logic [RES_W-1:0]              rsp_data,
    input  logic                          rsp_ready
`ifdef EXPR_ARB_STATS_EN
    ,
    input  logic                                    stat_clr,
    output logic [NUM_REQ*expr_arb_pkg::STAT_W-1:0] grant_cnt,
    output logic [expr_arb_pkg::BUSY_W-1:0]         busy_cnt
`endif
);
    import expr_arb_pkg::*;

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(SETTLE + 1);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [IDX_W-1:0]    r_ptr;
    logic [IDX_W-1:0]    r_id;
    logic [DATA_W-1:0]   r_op;
    logic [RES_W-1:0]    r_res;
    logic [CNT_W-1:0]    r_settle_cnt;
    logic [NUM_REQ-1:0]  w_gnt;
    logic [IDX_W-1:0]    w_gnt_idx;
    logic                w_idle;
    logic                w_accept;
    logic                w_settle_done;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (r_ptr),
        .en    (w_idle),
        .grant (w_gnt),
        .idx   (w_gnt_idx)
    );

    assign w_accept      = |w_gnt;
    assign w_settle_done = (r_state == HOLD) && (r_settle_cnt == CNT_W'(SETTLE - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)      w_state_nxt = HOLD;
            HOLD:    if (w_settle_done) w_state_nxt = RESP;
            RESP:    if (rsp_ready)     w_state_nxt = IDLE;
            default:                    w_state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state; the grant is already gated by w_idle.
    always_comb begin
        w_idle    = (r_state == IDLE);
        req_ready = w_gnt;
        rsp_valid = (r_state == RESP);
    end

    // Operand/tag latch on accept, settle counting and result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr        <= '0;
            r_id         <= '0;
            r_op         <= '0;
            r_res        <= '0;
            r_settle_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_op         <= req_data[int'(w_gnt_idx)*DATA_W +: DATA_W];
                r_id         <= w_gnt_idx;
                r_settle_cnt <= '0;
                r_ptr        <= (w_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + IDX_W'(1);
            end
            if (r_state == HOLD) begin
                r_settle_cnt <= r_settle_cnt + CNT_W'(1);
            end
            if (w_settle_done) begin
                r_res <= dp_out;
            end
        end
    end

    assign dp_in    = r_op;
    assign rsp_id   = r_id;
    assign rsp_data = r_res;

`ifdef EXPR_ARB_STATS_EN
    logic [STAT_W-1:0] r_grant_cnt [NUM_REQ];
    logic [BUSY_W-1:0] r_busy_cnt;

    // Saturating per-requester grant counts and wrapping busy-cycle count; clear wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy_cnt <= '0;
            for (int i = 0; i < NUM_REQ; i++) r_grant_cnt[i] <= '0;
        end else if (stat_clr) begin
            r_busy_cnt <= '0;
            for (int i = 0; i < NUM_REQ; i++) r_grant_cnt[i] <= '0;
        end else begin
            if (!w_idle) r_busy_cnt <= r_busy_cnt + BUSY_W'(1);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_gnt[i] && (r_grant_cnt[i] != {STAT_W{1'b1}})) begin
                    r_grant_cnt[i] <= r_grant_cnt[i] + STAT_W'(1);
                end
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt_pack
        assign grant_cnt[gi*STAT_W +: STAT_W] = r_grant_cnt[gi];
    end

    assign busy_cnt = r_busy_cnt;
`endif

endmodule

// File: tb/tb_expr_unit_arbiter.sv
// Bench for expr_unit_arbiter: directed scenarios plus random traffic,
// checked against a transaction-timeline reference model.
// Build with EXPR_ARB_STATS_EN defined to also check the statistics counters.
module tb_expr_unit_arbiter;

    localparam int NR     = 4;
    localparam int DW     = 4;
    localparam int RW     = 20;
    localparam int SETTLE = 2;
    localparam int IW     = $clog2(NR);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*DW-1:0]  req_data  = '0;
    logic [NR-1:0]     req_ready;
    logic [DW-1:0]     dp_in;
    logic [RW-1:0]     dp_out;
    logic              rsp_valid;
    logic [IW-1:0]     rsp_id;
    logic [RW-1:0]     rsp_data;
    logic              rsp_ready = 1'b0;
`ifdef EXPR_ARB_STATS_EN
    logic              stat_clr = 1'b0;
    logic [NR*16-1:0]  grant_cnt;
    logic [31:0]       busy_cnt;
`endif

    expr_unit_arbiter #(
        .NUM_REQ (NR),
        .DATA_W  (DW),
        .RES_W   (RW),
        .SETTLE  (SETTLE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .dp_in     (dp_in),
        .dp_out    (dp_out),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready)
`ifdef EXPR_ARB_STATS_EN
        ,
        .stat_clr  (stat_clr),
        .grant_cnt (grant_cnt),
        .busy_cnt  (busy_cnt)
`endif
    );

    // Expression unit stand-in: result is operand times three.
    assign dp_out = {{(RW-DW){1'b0}}, dp_in} * RW'(3);

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: an op is outstanding from accept until its response
    // is taken; the response becomes visible SETTLE+1 cycles after accept.
    int        cyc = 0;
    bit        m_busy = 0;
    int        m_acc = 0;
    int        m_ptr = 0;
    int        m_id = 0;
    int        m_op = 0;
    int        m_gcnt [NR];
    longint    m_bcnt = 0;
    int        grants [$];
    int        acc_cyc [$];
    int        rsp_log [$];
    int        first_rsp = -1;
    bit        drop_on_grant = 0;
    bit        rand_mode = 0;

    function automatic int rr_pick(input logic [NR-1:0] v, input int p);
        for (int k = 0; k < NR; k++) begin
            if (v[(p + k) % NR]) return (p + k) % NR;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0;
        m_ptr  = 0;
        m_bcnt = 0;
        for (int i = 0; i < NR; i++) m_gcnt[i] = 0;
        grants.delete();
        acc_cyc.delete();
        rsp_log.delete();
        first_rsp = -1;
    endtask

    // One cycle: check at negedge, advance model, move past the edge, drive.
    task automatic step();
        logic [NR-1:0] exp_rdy;
        int  g;
        bit  rphase;
        bit  idle;
        int  accepted;
        @(negedge clk);
        idle    = !m_busy;
        exp_rdy = '0;
        g       = idle ? rr_pick(req_valid, m_ptr) : -1;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        rphase = m_busy && (cyc >= m_acc + SETTLE + 1);
        chk("rsp_valid", 32'(rsp_valid), 32'(rphase));
        if (rphase) begin
            chk("rsp_id", 32'(rsp_id), 32'(m_id));
            chk("rsp_data", 32'(rsp_data), 32'(m_op * 3));
        end
        if (m_busy) chk("dp_in", 32'(dp_in), 32'(m_op));
        if (rsp_valid && first_rsp < 0) first_rsp = cyc;
        if (rsp_valid && rsp_ready) rsp_log.push_back(int'(rsp_data));
`ifdef EXPR_ARB_STATS_EN
        for (int i = 0; i < NR; i++) chk("grant_cnt", 32'(grant_cnt[i*16 +: 16]), 32'(m_gcnt[i]));
        chk("busy_cnt", busy_cnt, m_bcnt[31:0]);
        if (stat_clr) begin
            m_bcnt = 0;
            for (int i = 0; i < NR; i++) m_gcnt[i] = 0;
        end else begin
            if (m_busy) m_bcnt++;
            if (g >= 0 && m_gcnt[g] < 16'hFFFF) m_gcnt[g]++;
        end
`endif
        accepted = -1;
        if (g >= 0) begin
            m_busy = 1;
            m_acc  = cyc;
            m_id   = g;
            m_op   = int'(req_data[g*DW +: DW]);
            m_ptr  = (g + 1) % NR;
            grants.push_back(g);
            acc_cyc.push_back(cyc);
            accepted = g;
        end else if (rphase && rsp_ready) begin
            m_busy = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (accepted >= 0 && drop_on_grant) req_valid[accepted] = 1'b0;
        if (rand_mode) begin
            for (int i = 0; i < NR; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    req_valid[i] = 1'b1;
                    req_data[i*DW +: DW] = DW'($urandom_range(0, 15));
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
`ifdef EXPR_ARB_STATS_EN
            stat_clr = ($urandom_range(0, 40) == 0);
`endif
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        rand_mode = 0;
        drop_on_grant = 0;
`ifdef EXPR_ARB_STATS_EN
        stat_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_dp_in", 32'(dp_in), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_id", 32'(rsp_id), 32'h0);
        chk("rst_rsp_data", 32'(rsp_data), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    initial begin
        logic [RW-1:0] held_data;
        logic [IW-1:0] held_id;

        // Single request: operand A -> 0x1E, three cycles after accept.
        do_reset();
        req_data[3:0] = 4'hA;
        req_valid     = 4'b0001;
        rsp_ready     = 1'b1;
        drop_on_grant = 1;
        repeat (7) step();
        chk("single_grants", 32'(grants.size()), 32'd1);
        chk("single_id", 32'(grants[0]), 32'd0);
        chk("single_latency", 32'(first_rsp - acc_cyc[0]), 32'd3);
        chk("single_rsp_cnt", 32'(rsp_log.size()), 32'd1);
        chk("single_data", 32'(rsp_log[0]), 32'h1E);

        // All requesting from reset: order 0,1,2,3,0, one issue every 4 cycles.
        do_reset();
        req_data  = 16'h4321;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        repeat (20) step();
        for (int i = 0; i < 5; i++) chk("all_order", 32'(grants[i]), 32'(i % NR));
        for (int i = 0; i < 4; i++) chk("all_interval", 32'(acc_cyc[i+1] - acc_cyc[i]), 32'(SETTLE + 2));

        // Pointer wrap with only 2 and 3 requesting.
        do_reset();
        req_valid = 4'b1100;
        rsp_ready = 1'b1;
        repeat (12) step();
        chk("wrap_g0", 32'(grants[0]), 32'd2);
        chk("wrap_g1", 32'(grants[1]), 32'd3);
        chk("wrap_g2", 32'(grants[2]), 32'd2);

        // Response backpressure for 5 cycles in RESP.
        do_reset();
        req_data      = 16'h0975;
        req_valid     = 4'b0111;
        rsp_ready     = 1'b0;
        drop_on_grant = 1;
        repeat (3) step();
        chk("bp_in_resp", 32'(rsp_valid), 32'd1);
        held_data = rsp_data;
        held_id   = rsp_id;
        chk("bp_data_first", 32'(held_data), 32'h0F);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_data_stable", 32'(rsp_data), 32'(held_data));
            chk("bp_id_stable", 32'(rsp_id), 32'(held_id));
            chk("bp_ready_low", 32'(req_ready), 32'h0);
        end
        chk("bp_no_accept", 32'(grants.size()), 32'd1);
        rsp_ready = 1'b1;
        repeat (2) step();
        chk("bp_next_grant", 32'(grants[1]), 32'd1);

        // Reset during HOLD: everything clears, no response, next grant to 0.
        do_reset();
        req_data  = 16'h0300;
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        step();
        step();
        req_valid = '0;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_dp_in", 32'(dp_in), 32'h0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("mid_rst_rsp_data", 32'(rsp_data), 32'h0);
        chk("mid_rst_rsp_id", 32'(rsp_id), 32'h0);
        chk("mid_rst_req_ready", 32'(req_ready), 32'h0);
        repeat (3) begin
            @(negedge clk);
            chk("mid_rst_no_rsp", 32'(rsp_valid), 32'h0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        req_valid = 4'b1111;
        repeat (2) step();
        chk("mid_rst_next_grant", 32'(grants[0]), 32'd0);

        // Random traffic.
        do_reset();
        rand_mode     = 1;
        drop_on_grant = 1;
        repeat (600) step();
        rand_mode = 0;
        req_valid = '0;
        rsp_ready = 1'b1;
`ifdef EXPR_ARB_STATS_EN
        stat_clr = 1'b0;
`endif
        repeat (6) step();
        chk("rand_some_grants", 32'(grants.size() > 50), 32'd1);

`ifdef EXPR_ARB_STATS_EN
        // Three grants to requester 1, then clear.
        do_reset();
        req_valid = 4'b0010;
        rsp_ready = 1'b1;
        repeat (12) step();
        req_valid = '0;
        chk("stat_grant1", 32'(grant_cnt[31:16]), 32'd3);
        chk("stat_busy", busy_cnt, 32'(3 * (SETTLE + 1)));
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        chk("stat_clr_grant1", 32'(grant_cnt[31:16]), 32'd0);
        chk("stat_clr_busy", busy_cnt, 32'd0);
        repeat (2) step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
